// File: rtl/pe_frame_loader.sv
// pe_frame_loader: packs a serial RGB pixel stream into the pe's packed
// input vectors, then sequences the pe sum phase and the background removal
// phase, latching the saturated colour sums as the expected background.
// Optional watchdog on the pe wait states: define PE_LOADER_WATCHDOG_EN.
`timescale 1ns/1ps

// Clamp one colour sum to an 8-bit expected colour.
module pe_frame_loader_sat #(
  parameter int SW = 32
) (
  input  logic [SW-1:0] sum,
  output logic [7:0]    sat
);
  assign sat = (sum > SW'(255)) ? 8'hFF : sum[7:0];
endmodule

module pe_frame_loader #(
  parameter int NUM_PIXELS = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [7:0]              pix_r,
  input  logic [7:0]              pix_g,
  input  logic [7:0]              pix_b,
  input  logic                    pix_last,
  output logic [8*NUM_PIXELS-1:0] red_in,
  output logic [8*NUM_PIXELS-1:0] green_in,
  output logic [8*NUM_PIXELS-1:0] blue_in,
  output logic                    Start_Sum,
  output logic                    Start_BgRemoval,
  output logic                    Ack,
  input  logic                    Qsd,
  input  logic                    Qbgd,
  input  logic [8*NUM_PIXELS-1:0] red_sum,
  input  logic [8*NUM_PIXELS-1:0] green_sum,
  input  logic [8*NUM_PIXELS-1:0] blue_sum,
  output logic [7:0]              red_exp,
  output logic [7:0]              green_exp,
  output logic [7:0]              blue_exp,
  output logic                    frame_done,
  output logic                    err
);
  localparam int VW = 8*NUM_PIXELS;
  localparam int CW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  typedef enum logic [2:0] {FILL, SUM_GO, SUM_WAIT, BG_GO, BG_WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          bg_armed;   // low only in the first BG_WAIT cycle, where Qbgd may be stale
  logic          accept;
  logic          close;

  // Per-channel saturation, channel 0 = red, 1 = green, 2 = blue.
  logic [2:0][VW-1:0] sums;
  logic [2:0][7:0]    sat;
  assign sums = {blue_sum, green_sum, red_sum};

  for (genvar c = 0; c < 3; c++) begin : g_sat
    pe_frame_loader_sat #(.SW(VW)) u_sat (.sum(sums[c]), .sat(sat[c]));
  end

  // pix_ready is only ever high in FILL, so a handshake implies FILL.
  assign accept = pix_valid && pix_ready;
  assign close  = accept && (pix_last || (cnt == CW'(NUM_PIXELS-1)));

`ifdef PE_LOADER_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT+1);
  logic [WW-1:0] wd_cnt;
  logic          waiting;
  logic          done_hit;
  logic          timeout;

  assign waiting  = (state == SUM_WAIT) || (state == BG_WAIT);
  assign done_hit = ((state == SUM_WAIT) && Qsd) || ((state == BG_WAIT) && bg_armed && Qbgd);
  assign timeout  = waiting && !done_hit && (wd_cnt == WW'(TIMEOUT-1));

  // Wait-state cycle counter; the GO states in front of each wait clear it.
  always_ff @(posedge Clk) begin
    if (Reset || !waiting) wd_cnt <= '0;
    else                   wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  // Frame sequencer: fill, sum phase, latch background, removal phase, done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= FILL;
      pix_ready       <= 1'b1;
      cnt             <= '0;
      bg_armed        <= 1'b0;
      red_in          <= '0;
      green_in        <= '0;
      blue_in         <= '0;
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      Ack             <= 1'b0;
      frame_done      <= 1'b0;
      red_exp         <= '0;
      green_exp       <= '0;
      blue_exp        <= '0;
`ifdef PE_LOADER_WATCHDOG_EN
      err             <= 1'b0;
`endif
    end else begin
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      frame_done      <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < NUM_PIXELS; k++) begin
              if (k == int'(cnt)) begin
                red_in[8*k +: 8]   <= pix_r;
                green_in[8*k +: 8] <= pix_g;
                blue_in[8*k +: 8]  <= pix_b;
              end else if (pix_last && (k > int'(cnt))) begin
                // short frame: slots past the last pixel carry no stale data
                red_in[8*k +: 8]   <= '0;
                green_in[8*k +: 8] <= '0;
                blue_in[8*k +: 8]  <= '0;
              end
            end
            if (close) begin
              state     <= SUM_GO;
              pix_ready <= 1'b0;
              Start_Sum <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SUM_GO: begin
          state <= SUM_WAIT;
          Ack   <= 1'b1;
        end
        SUM_WAIT: begin
          if (Qsd) begin
            red_exp         <= sat[0];
            green_exp       <= sat[1];
            blue_exp        <= sat[2];
            Start_BgRemoval <= 1'b1;
            state           <= BG_GO;
          end
        end
        BG_GO: begin
          state    <= BG_WAIT;
          bg_armed <= 1'b0;
        end
        BG_WAIT: begin
          if (!bg_armed) begin
            bg_armed <= 1'b1;
          end else if (Qbgd) begin
            state      <= DONE;
            frame_done <= 1'b1;
            Ack        <= 1'b0;
          end
        end
        DONE: begin
          state     <= FILL;
          pix_ready <= 1'b1;
          cnt       <= '0;
        end
        default: state <= FILL;
      endcase
`ifdef PE_LOADER_WATCHDOG_EN
      // A stuck pe phase ends the frame early; exp outputs are left untouched.
      if (timeout) begin
        state      <= DONE;
        frame_done <= 1'b1;
        Ack        <= 1'b0;
        err        <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_pe_frame_loader.sv
// tb_pe_frame_loader: randomized frames against a behavioural pe model and
// scoreboard. Expected packed vectors and background colours are queued as
// stimulus is issued; a monitor pops and compares when the DUT pulses.
`timescale 1ns/1ps

module tb_pe_frame_loader;
  localparam int NP = 4;
  localparam int VW = 8*NP;
  localparam int TO = 16;

  logic          Clk, Reset;
  logic          pix_valid, pix_ready, pix_last;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic [VW-1:0] red_in, green_in, blue_in;
  logic          Start_Sum, Start_BgRemoval, Ack;
  logic          Qsd, Qbgd;
  logic [VW-1:0] red_sum, green_sum, blue_sum;
  logic [7:0]    red_exp, green_exp, blue_exp;
  logic          frame_done, err;

  pe_frame_loader #(.NUM_PIXELS(NP), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_last(pix_last),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
    .Qsd(Qsd), .Qbgd(Qbgd),
    .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .frame_done(frame_done), .err(err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected background colour: sums above 255 clamp to 255.
  function automatic logic [7:0] sat(input logic [VW-1:0] s);
    return (s > 255) ? 8'd255 : s[7:0];
  endfunction

  typedef struct { logic [VW-1:0] r, g, b; int cyc; } vec_t;
  typedef struct { logic [7:0] r, g, b; int cyc; } exp_t;
  vec_t vec_q[$];
  exp_t exp_q[$];

  logic [VW-1:0] plan_r, plan_g, plan_b;
  bit            pe_mute = 0;
  bit            wd_mode = 0;
  int            wd_fd_cyc = 0;
  int            qsd_cyc = -10;
  int            bg_done_cyc = -10;
  int            frames = 0;
  int            last_close_cyc = 0;

  // Behavioural pe: Qsd/Qbgd are level done flags. After Start_BgRemoval
  // the previous frame's Qbgd lingers for two more cycles before clearing.
  initial begin
    int sum_cnt, bg_stale, bg_cnt;
    exp_t e;
    sum_cnt = 0; bg_stale = 0; bg_cnt = 0;
    Qsd = 0; Qbgd = 0; red_sum = '0; green_sum = '0; blue_sum = '0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        Qsd = 0; Qbgd = 0; sum_cnt = 0; bg_stale = 0; bg_cnt = 0;
      end else begin
        if (Start_Sum) begin
          Qsd = 0;
          if (!pe_mute) sum_cnt = $urandom_range(1, 5);
        end else if (sum_cnt > 0) begin
          sum_cnt--;
          if (sum_cnt == 0) begin
            red_sum = plan_r; green_sum = plan_g; blue_sum = plan_b;
            Qsd = 1; qsd_cyc = cyc;
            e.r = sat(plan_r); e.g = sat(plan_g); e.b = sat(plan_b); e.cyc = cyc + 1;
            exp_q.push_back(e);
          end
        end
        if (Start_BgRemoval) bg_stale = 2;
        else if (bg_stale > 0) begin
          bg_stale--;
          if (bg_stale == 0) begin Qbgd = 0; bg_cnt = $urandom_range(1, 4); end
        end else if (bg_cnt > 0) begin
          bg_cnt--;
          if (bg_cnt == 0) begin Qbgd = 1; bg_done_cyc = cyc; end
        end
      end
    end
  end

  // Monitor: handshake levels every cycle, scoreboard pops on pulses.
  initial begin
    bit busy, err_exp;
    vec_t v;
    exp_t e;
    busy = 0; err_exp = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        busy = 0; err_exp = 0;
      end else begin
        if (Start_Sum) begin
          busy = 1;
          if (vec_q.size() == 0) chk("start_sum_unexpected", 1, 0);
          else begin
            v = vec_q.pop_front();
            chk("red_in", red_in, v.r);
            chk("green_in", green_in, v.g);
            chk("blue_in", blue_in, v.b);
            chk("start_sum_latency", cyc, v.cyc);
          end
        end
        if (Start_BgRemoval) begin
          if (exp_q.size() == 0) chk("start_bg_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("red_exp", red_exp, e.r);
            chk("green_exp", green_exp, e.g);
            chk("blue_exp", blue_exp, e.b);
            chk("start_bg_latency", cyc, e.cyc);
          end
        end
        chk("pix_ready", pix_ready, !busy);
        chk("ack", Ack, busy && !Start_Sum && !frame_done);
        if (frame_done) begin
          frames++;
          if (wd_mode) begin chk("wd_frame_done_cyc", cyc, wd_fd_cyc); err_exp = 1; end
          else chk("frame_done_latency", cyc, bg_done_cyc + 1);
          busy = 0;
        end
        chk("err", err, err_exp);
      end
    end
  end

  logic [7:0] fr_r[NP], fr_g[NP], fr_b[NP];

  task automatic send_frame(input int n, input bit use_last);
    vec_t v;
    bit   got;
    v.r = '0; v.g = '0; v.b = '0; v.cyc = 0;
    for (int k = 0; k < n; k++) begin
      v.r[8*k +: 8] = fr_r[k]; v.g[8*k +: 8] = fr_g[k]; v.b[8*k +: 8] = fr_b[k];
    end
    for (int k = 0; k < n; k++) begin
      pix_valid = 1; pix_r = fr_r[k]; pix_g = fr_g[k]; pix_b = fr_b[k];
      pix_last = use_last && (k == n-1);
      got = 0;
      for (int t = 0; t < 300 && !got; t++) begin
        if (pix_ready) begin
          got = 1;
          if (k == n-1) begin v.cyc = cyc + 1; last_close_cyc = v.cyc; vec_q.push_back(v); end
        end
        @(negedge Clk);
      end
      if (!got) chk("pix_accept_timeout", 0, 1);
    end
    pix_valid = 0; pix_last = 0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames < target && t < 500) begin @(negedge Clk); t++; end
    chk("frame_count", frames, target);
    @(negedge Clk);
  endtask

  task automatic do_reset(input int len);
    @(posedge Clk); #1 Reset = 1;
    vec_q.delete(); exp_q.delete();
    repeat (len) @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 1);
    chk({tag, "_ack"}, Ack, 0);
    chk({tag, "_start_sum"}, Start_Sum, 0);
    chk({tag, "_start_bg"}, Start_BgRemoval, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_red_in"}, red_in, 0);
    chk({tag, "_green_in"}, green_in, 0);
    chk({tag, "_blue_in"}, blue_in, 0);
    chk({tag, "_red_exp"}, red_exp, 0);
    chk({tag, "_green_exp"}, green_exp, 0);
    chk({tag, "_blue_exp"}, blue_exp, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, n, t;
    logic [VW-1:0] sl;
    Reset = 1; pix_valid = 0; pix_last = 0; pix_r = 0; pix_g = 0; pix_b = 0;
    plan_r = '0; plan_g = '0; plan_b = '0;
    sent = 0;
    do_reset(3);
    chk_reset_vals("reset");

    // Full frame, closed by count.
    fr_r = '{204, 61, 61, 61}; fr_g = '{0, 133, 133, 133}; fr_b = '{0, 198, 198, 198};
    plan_r = 164; plan_g = 99; plan_b = 148;
    send_frame(4, 0); sent++;
    wait_frames(sent);
    chk("full_red_vec", red_in, 32'h3D3D3DCC);
    chk("full_green_vec", green_in, 32'h85858500);
    chk("full_blue_vec", blue_in, 32'hC6C6C600);
    chk("full_red_exp", red_exp, 164);
    chk("full_green_exp", green_exp, 99);
    chk("full_blue_exp", blue_exp, 148);

    // Short frame: slots 2 and 3 must be cleared; plus saturation.
    fr_r = '{10, 20, 0, 0}; fr_g = '{30, 40, 0, 0}; fr_b = '{50, 60, 0, 0};
    plan_r = 300; plan_g = 40; plan_b = 256;
    send_frame(2, 1); sent++;
    wait_frames(sent);
    sl = red_in;
    chk("short_red_upper", sl[31:16], 0);
    chk("short_red_vec", red_in, 32'h0000140A);
    chk("sat_red_exp", red_exp, 255);
    chk("sat_green_exp", green_exp, 40);
    chk("sat_blue_exp", blue_exp, 255);

    // Randomized frames; half are back-to-back with pix_valid held high.
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, NP);
      for (int k = 0; k < NP; k++) begin
        fr_r[k] = 8'($urandom); fr_g[k] = 8'($urandom); fr_b[k] = 8'($urandom);
      end
      plan_r = VW'($urandom_range(0, 600));
      plan_g = VW'($urandom_range(250, 260));
      plan_b = ($urandom_range(0, 3) == 0) ? VW'($urandom) : VW'($urandom_range(0, 255));
      send_frame(n, (n < NP) ? 1'b1 : 1'($urandom_range(0, 1))); sent++;
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) @(negedge Clk);
    end
    wait_frames(sent);

    // Reset in BG_WAIT abandons the frame with no frame_done.
    fr_r = '{1, 2, 3, 4}; fr_g = '{5, 6, 7, 8}; fr_b = '{9, 10, 11, 12};
    plan_r = 77; plan_g = 88; plan_b = 99;
    send_frame(4, 1);
    t = 0;
    while (!Start_BgRemoval && t < 100) begin @(negedge Clk); t++; end
    chk("reach_bg_go", Start_BgRemoval, 1);
    do_reset(1);
    chk_reset_vals("midreset");
    repeat (8) @(negedge Clk);
    chk("midreset_no_done", frames, sent);

`ifdef PE_LOADER_WATCHDOG_EN
    // pe never reports sum done: watchdog ends the frame and sets err.
    pe_mute = 1; wd_mode = 1;
    send_frame(4, 0); sent++;
    wd_fd_cyc = last_close_cyc + 1 + TO;
    wait_frames(sent);
    repeat (5) @(negedge Clk);
    chk("wd_err_sticky", err, 1);
    do_reset(1);
    pe_mute = 0; wd_mode = 0;
    chk("wd_err_cleared", err, 0);
`endif

    // Traffic after the reset still works.
    plan_r = 1000; plan_g = 255; plan_b = 0;
    for (int k = 0; k < NP; k++) begin fr_r[k] = 8'(k+1); fr_g[k] = 8'(k+2); fr_b[k] = 8'(k+3); end
    send_frame(3, 1); sent++;
    wait_frames(sent);
    chk("post_red_exp", red_exp, 255);
    chk("post_green_exp", green_exp, 255);
    chk("post_blue_exp", blue_exp, 0);
    chk("queues_drained", vec_q.size() + exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_frame_loader.md
Name: pe_frame_loader

Overview:
- Upstream sequencer for the background-removal processing element (pe).
- Accepts a serial RGB pixel stream, packs NUM_PIXELS pixels into the pe's packed red/green/blue input vectors, then runs the pe's two phases back-to-back: colour sum, then background removal.
- Between the phases it latches the pe's colour sums as the expected background colour.
- Signals frame completion, so the pe's output vectors can be consumed downstream.

Parameters:
- NUM_PIXELS, 4, pixels per frame; packed vector width is 8*NUM_PIXELS.
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  loader can accept a pixel.
- pix_r, pix_g, pix_b  in  8 each  pixel colour.
- pix_last  in  1  final pixel of the frame.
- red_in, green_in, blue_in  out  8*NUM_PIXELS each  packed pixels to the pe; pixel k occupies bits [8k+7:8k].
- Start_Sum  out  1  one-cycle pulse that starts the pe sum phase.
- Start_BgRemoval  out  1  one-cycle pulse that starts the pe removal phase.
- Ack  out  1  acknowledge to the pe.
- Qsd  in  1  pe sum-done state flag.
- Qbgd  in  1  pe removal-done state flag.
- red_sum, green_sum, blue_sum  in  8*NUM_PIXELS each  pe colour sums.
- red_exp, green_exp, blue_exp  out  8 each  expected background colour to the pe.
- frame_done  out  1  one-cycle pulse when pe outputs are valid.
- err  out  1  sticky timeout flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset values:
  - state = FILL; pix_ready = 1; packed vectors = 0; fill count = 0.
  - Start_Sum, Start_BgRemoval, Ack, frame_done = 0; exp outputs = 0; err = 0.
- Reset asserted in any state returns the block to these values on the next edge. A pe phase already in flight is abandoned; the pe must be reset alongside.
- FILL:
  - pix_ready = 1. On pix_valid, write the pixel into slot cnt and increment cnt.
  - Frame closes when cnt reaches NUM_PIXELS-1 or pix_last = 1, whichever comes first. If both happen on the same pixel, the frame closes once.
  - Short frame (pix_last before the last slot): unwritten slots are forced to 0 in the same cycle.
  - On close: go to SUM_GO.
- SUM_GO:
  - Start_Sum = 1 for exactly one cycle; pix_ready = 0 (and stays 0 outside FILL).
  - Go to SUM_WAIT.
- SUM_WAIT:
  - Ack = 1 from here until the frame completes.
  - When Qsd = 1, latch each exp output from its sum. If the sum is ≤ 255, use sum[7:0]; otherwise saturate to 255.
  - Go to BG_GO.
- BG_GO:
  - Start_BgRemoval = 1 for one cycle; exp outputs are stable in this cycle.
  - Go to BG_WAIT.
- BG_WAIT:
  - Ignore Qbgd during the first cycle after BG_GO, because the pe may still report done from the prior frame.
  - After that, Qbgd = 1 moves the block to DONE.
- DONE:
  - frame_done = 1 for one cycle; Ack = 0; cnt = 0.
  - Go to FILL; pix_ready returns to 1 on the following cycle.
- Packed vectors hold their values from frame close until the next FILL write.
- Latency:
  - Start_Sum rises one cycle after the closing pixel handshake.
  - frame_done rises one cycle after the accepted Qbgd.
- pix_valid while pix_ready = 0 is ignored; no data is lost because the source must hold the pixel.

Optional Feature:
- Macro: PE_LOADER_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in SUM_WAIT and BG_WAIT and clears on each state entry.
  - Reaching TIMEOUT without the expected done flag sets err (sticky until Reset), pulses frame_done, and returns to FILL. exp outputs keep their previous values.
- Undefined: no counter exists, err is tied 0, and the wait states wait indefinitely.

Test Plan:
- Full frame: pixels (204,0,0), (61,133,198) x3, then pe model Qsd with sums 164/99/148, then Qbgd → red_in = {61,61,61,204}, green_in = {133,133,133,0}, blue_in = {198,198,198,0}; Start_Sum pulses once; exp = 164/99/148 in the Start_BgRemoval cycle; one frame_done pulse.
- Short frame: 2 pixels with pix_last on the 2nd → slots 2 and 3 = 0; Start_Sum one cycle after the 2nd handshake.
- Saturation: red_sum = 300 at Qsd → red_exp = 255; green_sum = 40 → green_exp = 40.
- Backpressure: pix_valid held high through SUM_WAIT and BG_WAIT → no pixel accepted until the cycle after frame_done; the next frame fills correctly.
- Reset mid-frame: Reset in BG_WAIT → next cycle state FILL, Ack = 0, exp = 0, pix_ready = 1, no frame_done pulse.
- Watchdog (macro defined, TIMEOUT = 16): Qsd never asserted → err = 1 and a frame_done pulse 16 cycles after SUM_WAIT entry; err stays 1 until Reset.
